// File: rtl/ps2_key_event_pkg.sv
// ps2_pkg: shared constants, FSM state and event types for the PS/2 key-event decoder
package ps2_pkg;
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;
  localparam logic [7:0] KEY_UP = 8'h75;
  localparam logic [7:0] KEY_DOWN = 8'h72;
  localparam logic [7:0] KEY_LEFT = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  // State bits double as the pending {break,ext} prefix flags.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXT = 2'b01,
    ST_BRK = 2'b10,
    ST_EXT_BRK = 2'b11
  } state_t;
  typedef struct packed {
    logic ext;
    logic brk;
    logic [7:0] code;
  } event_t;
  // Controller response bytes carry no key information.
  function automatic logic is_resp(input logic [7:0] code);
    return code inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  endfunction
  // One-hot {up,down,left,right} position of an arrow code, 0 otherwise.
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    return {code == KEY_UP, code == KEY_DOWN, code == KEY_LEFT, code == KEY_RIGHT};
  endfunction
endpackage

// File: rtl/ps2_key_event_if.sv
// ps2_key_event_if: scan-code input, event-queue read side and status of the key-event decoder
//   master: drives scan_done_tick/scan_code/rd_event, observes the event head and status
//   slave : the decoder side
interface ps2_key_event_if;
  logic scan_done_tick;
  logic [7:0] scan_code;
  logic rd_event;
  logic empty;
  logic [7:0] ev_code;
  logic ev_ext;
  logic ev_break;
  logic overflow;
  logic [3:0] dir_held;
  modport master (
    output scan_done_tick, scan_code, rd_event,
    input empty, ev_code, ev_ext, ev_break, overflow, dir_held
  );
  modport slave (
    input scan_done_tick, scan_code, rd_event,
    output empty, ev_code, ev_ext, ev_break, overflow, dir_held
  );
endinterface

// File: rtl/ps2_key_event_fifo.sv
// ps2_event_fifo: show-ahead register-file FIFO of 2^W_SIZE key events
//   push_i/din_i : write request and data (accepted if not full, or full with a pop)
//   pop_i        : pop request (ignored when empty)
//   full_o/empty_o, dout_o : status and head entry (0 when empty)
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int W_SIZE = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push_i,
  input  event_t din_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output event_t dout_o
);
  event_t mem_q [2**W_SIZE];
  logic [W_SIZE-1:0] wr_q, rd_q;
  logic [W_SIZE:0] cnt_q;
  logic pop_en, push_en;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q[W_SIZE];
  assign pop_en = pop_i & ~empty_o;
  // A pop frees the slot a full-FIFO push needs in the same cycle.
  assign push_en = push_i & (~full_o | pop_en);
  assign dout_o = empty_o ? '0 : mem_q[rd_q];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + W_SIZE'(push_en);
      rd_q <= rd_q + W_SIZE'(pop_en);
      cnt_q <= cnt_q + (W_SIZE+1)'(push_en) - (W_SIZE+1)'(pop_en);
    end
  always_ff @(posedge clk)
    if (push_en) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/ps2_key_event.sv
// ps2_key_event: folds E0/F0 prefixes into make/break events, queues them, tracks arrow-key hold state
//   clk, reset : clock and asynchronous active-high reset
//   bus        : scan-code strobe/byte in, event head/pop, overflow and dir_held out
module ps2_key_event
  import ps2_pkg::*;
#(
  parameter int W_SIZE = 2
) (
  input logic clk,
  input logic reset,
  ps2_key_event_if.slave bus
);
  state_t state_q, state_d;
  logic overflow_q, overflow_d;
  logic [3:0] dir_q, dir_d, mask;
  logic tick, is_e0, is_f0, emit, full, empty;
  event_t ev, head;
  assign tick = bus.scan_done_tick & ~is_resp(bus.scan_code);
  assign is_e0 = bus.scan_code == PFX_EXT;
  assign is_f0 = bus.scan_code == PFX_BRK;
  assign emit = tick & ~is_e0 & ~is_f0;
  assign ev = '{ext: state_q[0], brk: state_q[1], code: bus.scan_code};
  assign mask = arrow_mask(bus.scan_code);
  // Prefixes accumulate into the state bits in any order; a key byte closes the event.
  assign state_d = !tick ? state_q : emit ? ST_IDLE : state_t'(state_q | {is_f0, is_e0});
  // A full FIFO only has room if the head is popped this cycle.
  assign overflow_d = overflow_q | (emit & full & ~bus.rd_event);
  assign dir_d = (emit & ev.ext) ? (ev.brk ? dir_q & ~mask : dir_q | mask) : dir_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      overflow_q <= 1'b0;
      dir_q <= '0;
    end else begin
      state_q <= state_d;
      overflow_q <= overflow_d;
      dir_q <= dir_d;
    end
  ps2_event_fifo #(.W_SIZE(W_SIZE)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (emit),
    .din_i  (ev),
    .pop_i  (bus.rd_event),
    .full_o (full),
    .empty_o(empty),
    .dout_o (head)
  );
  assign bus.empty = empty;
  assign bus.ev_code = head.code;
  assign bus.ev_ext = head.ext;
  assign bus.ev_break = head.brk;
  assign bus.overflow = overflow_q;
  assign bus.dir_held = dir_q;
endmodule

// File: tb/tb_ps2_key_event.sv
// tb_ps2_key_event: directed self-checking bench for ps2_key_event
module tb_ps2_key_event;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  ps2_key_event_if bus ();
  ps2_key_event #(.W_SIZE(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic head(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    chk({tag, ".empty"}, 16'(bus.empty), 16'd0);
    chk({tag, ".head"}, {6'd0, bus.ev_ext, bus.ev_break, bus.ev_code}, {6'd0, ext, brk, code});
  endtask
  task automatic send(input logic [7:0] b);
    bus.scan_done_tick = 1'b1;
    bus.scan_code = b;
    @(posedge clk);
    #1;
    bus.scan_done_tick = 1'b0;
  endtask
  task automatic pop();
    bus.rd_event = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_event = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.scan_done_tick = 1'b0;
    bus.scan_code = 8'h00;
    bus.rd_event = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst.empty", 16'(bus.empty), 16'd1);
    chk("rst.head", {6'd0, bus.ev_ext, bus.ev_break, bus.ev_code}, 16'h0000);
    chk("rst.ovf", 16'(bus.overflow), 16'd0);
    chk("rst.dir", 16'(bus.dir_held), 16'h0);
    // make then break of a plain key, back-to-back strobes
    send(8'h1C);
    head("mk1C", 8'h1C, 1'b0, 1'b0);
    send(8'hF0);
    send(8'h1C);
    head("mk1C_still", 8'h1C, 1'b0, 1'b0);
    pop();
    head("brk1C", 8'h1C, 1'b0, 1'b1);
    pop();
    chk("empty1", 16'(bus.empty), 16'd1);
    chk("empty1.code", 16'(bus.ev_code), 16'h0);
    // extended arrow up make/break drives dir_held[3]
    send(8'hE0);
    chk("up.pre", 16'(bus.dir_held), 16'h0);
    send(8'h75);
    chk("up.held", 16'(bus.dir_held), 16'h8);
    head("up.mk", 8'h75, 1'b1, 1'b0);
    send(8'hE0);
    send(8'hF0);
    chk("up.still", 16'(bus.dir_held), 16'h8);
    send(8'h75);
    chk("up.rel", 16'(bus.dir_held), 16'h0);
    pop();
    head("up.brk", 8'h75, 1'b1, 1'b1);
    pop();
    chk("empty2", 16'(bus.empty), 16'd1);
    // overflow on fifth event with no pops
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    chk("ovf.before", 16'(bus.overflow), 16'd0);
    send(8'h2C);
    chk("ovf.after", 16'(bus.overflow), 16'd1);
    head("ovf.h0", 8'h15, 1'b0, 1'b0);
    pop();
    head("ovf.h1", 8'h1D, 1'b0, 1'b0);
    pop();
    head("ovf.h2", 8'h24, 1'b0, 1'b0);
    pop();
    head("ovf.h3", 8'h2D, 1'b0, 1'b0);
    pop();
    chk("ovf.empty", 16'(bus.empty), 16'd1);
    chk("ovf.sticky", 16'(bus.overflow), 16'd1);
    // push while full with a simultaneous pop is accepted
    do_reset();
    chk("rst2.ovf", 16'(bus.overflow), 16'd0);
    send(8'h11);
    send(8'h12);
    send(8'h13);
    send(8'h14);
    bus.rd_event = 1'b1;
    send(8'h21);
    bus.rd_event = 1'b0;
    chk("fullpop.ovf", 16'(bus.overflow), 16'd0);
    head("fullpop.h0", 8'h12, 1'b0, 1'b0);
    pop();
    head("fullpop.h1", 8'h13, 1'b0, 1'b0);
    pop();
    head("fullpop.h2", 8'h14, 1'b0, 1'b0);
    pop();
    head("fullpop.h3", 8'h21, 1'b0, 1'b0);
    pop();
    chk("fullpop.empty", 16'(bus.empty), 16'd1);
    // response bytes are dropped without disturbing the prefix state
    send(8'hAA);
    chk("resp.empty", 16'(bus.empty), 16'd1);
    send(8'hE0);
    send(8'hFA);
    chk("resp.empty2", 16'(bus.empty), 16'd1);
    send(8'h74);
    head("right.mk", 8'h74, 1'b1, 1'b0);
    chk("right.held", 16'(bus.dir_held), 16'h1);
    pop();
    chk("resp.single", 16'(bus.empty), 16'd1);
    // keypad (non-extended) arrow code leaves dir_held alone
    send(8'hF0);
    send(8'h74);
    chk("keypad.dir", 16'(bus.dir_held), 16'h1);
    head("keypad.brk", 8'h74, 1'b0, 1'b1);
    pop();
    // reset mid-sequence discards pending prefixes
    send(8'hE0);
    send(8'hF0);
    do_reset();
    chk("midrst.empty", 16'(bus.empty), 16'd1);
    send(8'h6B);
    head("midrst.ev", 8'h6B, 1'b0, 1'b0);
    chk("midrst.dir", 16'(bus.dir_held), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
